// File: rtl/uart_fir_pkg.sv
// Shared types and elaboration helpers for the UART <-> FIR sequencer.
package uart_fir_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_e;

    function automatic int unsigned byte_count(input int unsigned width);
        return width / 8;
    endfunction

    function automatic bit width_legal(input int unsigned width);
        return (width % 8 == 0) && (width >= 8) && (width <= 32);
    endfunction

endpackage

// File: rtl/uart_fir_tx_seq.sv
// Serializes one FIR result LSB-byte-first into the UART transmitter via start/busy pulses.
module uart_fir_tx_seq
    import uart_fir_pkg::*;
#(
    parameter int unsigned OUT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fir_out_valid,
    output logic             fir_out_ready,
    input  logic [OUT_W-1:0] fir_out_data,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic             active
);

    localparam int unsigned OUT_BYTES = byte_count(OUT_W);
    localparam logic [1:0]  LAST_IDX  = 2'(OUT_BYTES - 1);

    tx_state_e        state_q;
    logic [OUT_W-1:0] shift_q;
    logic [1:0]       idx_q;
    logic             ready_q;
    logic             start_q;
    logic [7:0]       data_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fir_out_valid && ready_q) begin
                        ready_q <= 1'b0;
                        idx_q   <= '0;
                        // Launch byte 0 straight from IDLE so tx_start follows the handshake by one cycle.
                        if (!tx_busy) begin
                            start_q <= 1'b1;
                            data_q  <= fir_out_data[7:0];
                            shift_q <= fir_out_data >> 8;
                            state_q <= WAIT_HI;
                        end else begin
                            shift_q <= fir_out_data;
                            state_q <= SEND;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        start_q <= 1'b1;
                        data_q  <= shift_q[7:0];
                        shift_q <= shift_q >> 8;
                        state_q <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy) state_q <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx_q == LAST_IDX) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= SEND;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fir_out_ready = ready_q;
    assign tx_start      = start_q;
    assign tx_data       = data_q;
    assign active        = (state_q != IDLE);

endmodule

// File: rtl/uart_fir_ctrl.sv
// Assembles RX bytes into FIR samples and forwards FIR results to the TX sequencer.
// Optional overrun status ports are enabled by defining UART_FIR_CTRL_OVR_EN.
module uart_fir_ctrl
    import uart_fir_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_data_ready,
    input  logic [7:0]       rx_data,
    output logic             fir_in_valid,
    input  logic             fir_in_ready,
    output logic [IN_W-1:0]  fir_in_data,
    input  logic             fir_out_valid,
    output logic             fir_out_ready,
    input  logic [OUT_W-1:0] fir_out_data,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_busy,
    output logic             busy
`ifdef UART_FIR_CTRL_OVR_EN
    ,
    output logic             ovr_flag,
    output logic [7:0]       ovr_cnt
`endif
);

    localparam int unsigned IN_BYTES  = byte_count(IN_W);
    localparam logic [1:0]  LAST_LANE = 2'(IN_BYTES - 1);

    if (!width_legal(IN_W) || !width_legal(OUT_W)) begin : g_width_check
        $error("uart_fir_ctrl: IN_W and OUT_W must be multiples of 8 within 8..32");
    end

    logic [1:0]      cnt_q, cnt_d;
    logic [IN_W-1:0] asm_q, asm_d;
    logic [IN_W-1:0] hold_q;
    logic            hold_valid_q;
    logic            complete, drain, load;
    logic            tx_active;

    always_comb begin
        asm_d = asm_q;
        cnt_d = cnt_q;
        if (rx_data_ready) begin
            for (int unsigned i = 0; i < IN_BYTES; i++) begin
                if (cnt_q == 2'(i)) asm_d[i*8 +: 8] = rx_data;
            end
            cnt_d = (cnt_q == LAST_LANE) ? '0 : cnt_q + 2'd1;
        end
    end

    assign complete = rx_data_ready && (cnt_q == LAST_LANE);
    assign drain    = hold_valid_q && fir_in_ready;
    assign load     = complete && (!hold_valid_q || drain);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            if (load) begin
                hold_q       <= asm_d;
                hold_valid_q <= 1'b1;
            end else if (drain) begin
                hold_valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_FIR_CTRL_OVR_EN
    logic       overrun;
    logic       ovr_flag_q;
    logic [7:0] ovr_cnt_q;

    assign overrun = complete && hold_valid_q && !fir_in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovr_flag_q <= 1'b0;
            ovr_cnt_q  <= '0;
        end else if (overrun) begin
            ovr_flag_q <= 1'b1;
            if (ovr_cnt_q != '1) ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
    end

    assign ovr_flag = ovr_flag_q;
    assign ovr_cnt  = ovr_cnt_q;
`endif

    uart_fir_tx_seq #(
        .OUT_W(OUT_W)
    ) u_tx_seq (
        .clk          (clk),
        .rst          (rst),
        .fir_out_valid(fir_out_valid),
        .fir_out_ready(fir_out_ready),
        .fir_out_data (fir_out_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .active       (tx_active)
    );

    assign fir_in_valid = hold_valid_q;
    assign fir_in_data  = hold_q;
    assign busy         = (cnt_q != '0) || hold_valid_q || tx_active;

endmodule

// File: tb/tb_uart_fir_ctrl.sv
// Self-checking bench for uart_fir_ctrl: RX assembly table, overrun, TX serialization and reset corners.
module tb_uart_fir_ctrl;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 24;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_data_ready;
    logic [7:0]       rx_data;
    logic             fir_in_valid;
    logic             fir_in_ready;
    logic [IN_W-1:0]  fir_in_data;
    logic             fir_out_valid;
    logic             fir_out_ready;
    logic [OUT_W-1:0] fir_out_data;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy = 1'b0;
    logic             busy;
`ifdef UART_FIR_CTRL_OVR_EN
    logic             ovr_flag;
    logic [7:0]       ovr_cnt;
`endif

    always #5 clk = ~clk;

    uart_fir_ctrl #(
        .IN_W (IN_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data_ready(rx_data_ready),
        .rx_data      (rx_data),
        .fir_in_valid (fir_in_valid),
        .fir_in_ready (fir_in_ready),
        .fir_in_data  (fir_in_data),
        .fir_out_valid(fir_out_valid),
        .fir_out_ready(fir_out_ready),
        .fir_out_data (fir_out_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .busy         (busy)
`ifdef UART_FIR_CTRL_OVR_EN
        ,
        .ovr_flag     (ovr_flag),
        .ovr_cnt      (ovr_cnt)
`endif
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_starts = 0;
    int unsigned cyc      = 0;
    int unsigned fall_cyc = 0;
    int unsigned busy_cnt = 0;
    bit          pend       = 1'b0;
    bit          force_busy = 1'b0;
    logic        prev_start = 1'b0;

    logic [IN_W-1:0] rx_exp[$];
    logic [7:0]      tx_exp[$];

    typedef struct {
        logic [7:0]      b0;
        logic [7:0]      b1;
        logic [IN_W-1:0] exp;
    } rx_vec_t;
    rx_vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transmitter model: busy rises one cycle after tx_start and stays high for 10 cycles.
    always @(negedge clk) begin
        if (pend) begin
            busy_cnt = 10;
            pend     = 1'b0;
        end else if (busy_cnt != 0) begin
            busy_cnt--;
            if (busy_cnt == 0) fall_cyc = cyc;
        end
        if (tx_start) pend = 1'b1;
        tx_busy = force_busy || (busy_cnt != 0);
    end

    // Scoreboard monitor: looks just after the drive point, before the next rising edge.
    always begin
        @(negedge clk);
        #1;
        if (rst && fir_in_valid && fir_in_ready) begin
            if (rx_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL fir_in_extra: got sample 0x%0h, required none", fir_in_data);
            end else begin
                check("fir_in_data_hs", 32'(fir_in_data), 32'(rx_exp.pop_front()));
            end
        end
        if (tx_start) begin
            n_starts++;
            check("tx_start_spacing", {30'd0, prev_start, tx_busy}, 32'd0);
            if (tx_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL tx_extra: got byte 0x%0h, required none", tx_data);
            end else begin
                check("tx_data", 32'(tx_data), 32'(tx_exp.pop_front()));
            end
        end
        prev_start = tx_start;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_ready = 1'b1;
        rx_data       = b;
        @(negedge clk);
        rx_data_ready = 1'b0;
    endtask

    task automatic wait_out_ready(input int unsigned budget);
        int unsigned n = 0;
        while (!fir_out_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!fir_out_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_ready_timeout: got 0, required 1 within %0d cycles", budget);
        end
    endtask

    task automatic wait_busy_low(input int unsigned budget);
        int unsigned n = 0;
        while (tx_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_result(input logic [OUT_W-1:0] d);
        wait_out_ready(50);
        fir_out_valid = 1'b1;
        fir_out_data  = d;
        @(negedge clk);
        fir_out_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_valid"},  32'(fir_in_valid),  32'd0);
        check({tag, "_in_data"},   32'(fir_in_data),   32'd0);
        check({tag, "_out_ready"}, 32'(fir_out_ready), 32'd0);
        check({tag, "_tx_start"},  32'(tx_start),      32'd0);
        check({tag, "_tx_data"},   32'(tx_data),       32'd0);
        check({tag, "_busy"},      32'(busy),          32'd0);
`ifdef UART_FIR_CTRL_OVR_EN
        check({tag, "_ovr_flag"},  32'(ovr_flag),      32'd0);
        check({tag, "_ovr_cnt"},   32'(ovr_cnt),       32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s0;
        int unsigned n;

        vecs[0] = '{b0: 8'h34, b1: 8'h12, exp: 16'h1234};
        vecs[1] = '{b0: 8'hFF, b1: 8'h00, exp: 16'h00FF};
        vecs[2] = '{b0: 8'h00, b1: 8'hFF, exp: 16'hFF00};
        vecs[3] = '{b0: 8'hA5, b1: 8'h5A, exp: 16'h5AA5};

        rst           = 1'b0;
        rx_data_ready = 1'b0;
        rx_data       = '0;
        fir_in_ready  = 1'b1;
        fir_out_valid = 1'b0;
        fir_out_data  = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);
        check("out_ready_after_rst", 32'(fir_out_ready), 32'd1);

        // Table-driven sample assembly with the FIR always ready.
        for (int i = 0; i < 4; i++) begin
            rx_exp.push_back(vecs[i].exp);
            send_byte(vecs[i].b0);
            check("busy_partial", 32'(busy), 32'd1);
            check("valid_partial", 32'(fir_in_valid), 32'd0);
            send_byte(vecs[i].b1);
            check("valid_rise", 32'(fir_in_valid), 32'd1);
            check("sample_data", 32'(fir_in_data), 32'(vecs[i].exp));
            @(negedge clk);
            check("valid_clear", 32'(fir_in_valid), 32'd0);
        end

        // Overrun: second complete sample dropped while the first is held.
        fir_in_ready = 1'b0;
        rx_exp.push_back(16'h0201);
        send_byte(8'h01);
        send_byte(8'h02);
        check("hold_valid", 32'(fir_in_valid), 32'd1);
        check("hold_data", 32'(fir_in_data), 32'h0201);
        send_byte(8'h03);
        send_byte(8'h04);
        check("ovr_keep_valid", 32'(fir_in_valid), 32'd1);
        check("ovr_keep_data", 32'(fir_in_data), 32'h0201);
`ifdef UART_FIR_CTRL_OVR_EN
        check("ovr_flag_set", 32'(ovr_flag), 32'd1);
        check("ovr_cnt_one", 32'(ovr_cnt), 32'd1);
`endif

        // Last byte lands in the same cycle as the drain handshake.
        send_byte(8'h05);
        @(negedge clk);
        rx_data_ready = 1'b1;
        rx_data       = 8'h06;
        fir_in_ready  = 1'b1;
        rx_exp.push_back(16'h0605);
        @(negedge clk);
        rx_data_ready = 1'b0;
        check("same_cycle_valid", 32'(fir_in_valid), 32'd1);
        check("same_cycle_data", 32'(fir_in_data), 32'h0605);
`ifdef UART_FIR_CTRL_OVR_EN
        check("same_cycle_no_ovr", 32'(ovr_cnt), 32'd1);
`endif
        @(negedge clk);
        check("same_cycle_clear", 32'(fir_in_valid), 32'd0);

        // TX serialization of 0xABCDEF, LSB byte first.
        wait_busy_low(50);
        s0 = n_starts;
        tx_exp.push_back(8'hEF);
        tx_exp.push_back(8'hCD);
        tx_exp.push_back(8'hAB);
        send_result(24'hABCDEF);
        check("tx_start_latency", 32'(tx_start), 32'd1);
        check("tx_first_byte", 32'(tx_data), 32'hEF);
        check("out_ready_low", 32'(fir_out_ready), 32'd0);
        wait_out_ready(200);
        check("tx_byte_count", n_starts - s0, 32'd3);
        check("ready_after_fall", cyc - fall_cyc, 32'd1);

        // Transmitter held busy: no start until it frees, then exactly one.
        force_busy = 1'b1;
        @(negedge clk);
        s0 = n_starts;
        tx_exp.push_back(8'h11);
        tx_exp.push_back(8'h22);
        tx_exp.push_back(8'h33);
        send_result(24'h332211);
        for (int i = 0; i < 5; i++) begin
            check("start_held", 32'(tx_start), 32'd0);
            @(negedge clk);
        end
        force_busy = 1'b0;
        repeat (6) @(negedge clk);
        check("single_start", n_starts - s0, 32'd1);
        wait_out_ready(200);
        check("held_byte_count", n_starts - s0, 32'd3);

        // Reset mid-sample and during the second TX byte, with an RX pulse on the reset cycle.
        send_byte(8'h99);
        s0 = n_starts;
        tx_exp.push_back(8'h66);
        tx_exp.push_back(8'h55);
        tx_exp.push_back(8'h44);
        send_result(24'h445566);
        n = 0;
        while ((n_starts - s0) < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("second_byte_seen", n_starts - s0, 32'd2);
        repeat (3) @(negedge clk);
        rst           = 1'b0;
        rx_data_ready = 1'b1;
        rx_data       = 8'hAA;
        @(negedge clk);
        rx_data_ready = 1'b0;
        check_reset_outputs("mid_rst");
        tx_exp.delete();
        rst = 1'b1;
        @(negedge clk);
        check("out_ready_rerise", 32'(fir_out_ready), 32'd1);
        wait_busy_low(50);
        rx_exp.push_back(16'h5678);
        send_byte(8'h78);
        send_byte(8'h56);
        check("post_rst_valid", 32'(fir_in_valid), 32'd1);
        check("post_rst_data", 32'(fir_in_data), 32'h5678);
        repeat (3) @(negedge clk);

        check("rx_queue_empty", rx_exp.size(), 32'd0);
        check("tx_queue_empty", tx_exp.size(), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
